// File: rtl/uart_trig_rx.sv
// 8N1 UART receiver with a one-cycle capture trigger strobe.
// Optional UART_TRIG_CMD_FILTER_EN: trig fires only on TRIG_BYTE instead of on every good byte.
module uart_trig_rx #(
    parameter int unsigned sym_cnt   = 40000,
    parameter int unsigned SCW       = $clog2(sym_cnt)
`ifdef UART_TRIG_CMD_FILTER_EN
    ,
    parameter logic [7:0]  TRIG_BYTE = 8'h44
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] rx_dat,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       trig,
    output logic       rx_busy
);

    localparam logic [SCW-1:0] HALF_M1 = SCW'(sym_cnt / 2 - 1);
    localparam logic [SCW-1:0] FULL_M1 = SCW'(sym_cnt - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d;
    logic           rxs_q, rxs_d;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_dat_q, rx_dat_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_frame_err_q, rx_frame_err_d;
    logic           trig_q, trig_d;
    logic           rx_busy_q, rx_busy_d;
    logic           accept;

    // Next-state, datapath and strobe computation.
    always_comb begin
        state_d        = state_q;
        sync1_d        = rx_serial;
        rxs_d          = sync1_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        rx_dat_d       = rx_dat_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
        accept         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                // Half-bit wait lands the data samples at bit centres.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'(1);
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        accept     = 1'b1;
                        rx_dat_d   = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        state_d        = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + SCW'(1);
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

`ifdef UART_TRIG_CMD_FILTER_EN
        trig_d = accept && (shift_q == TRIG_BYTE);
`else
        trig_d = accept;
`endif
        rx_busy_d = (state_d != S_IDLE);
    end

    // State and output registers; synchroniser resets to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b1;
            rxs_q          <= 1'b1;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_dat_q       <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            trig_q         <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            rxs_q          <= rxs_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            rx_dat_q       <= rx_dat_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            trig_q         <= trig_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_dat       = rx_dat_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign trig         = trig_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_trig_rx.sv
// Scoreboard bench for uart_trig_rx: driver queues expected strobes, monitor checks them.
module tb_uart_trig_rx;

    localparam int unsigned SYM = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b0;
    logic [7:0] rx_dat;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       trig;
    logic       rx_busy;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic       is_valid;
        logic [7:0] dat;
        logic       trig;
    } exp_t;

    exp_t exp_q[$];
    time  last_valid_t = 0;

    uart_trig_rx #(.sym_cnt(SYM), .SCW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .rx_dat      (rx_dat),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .trig        (trig),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    function automatic logic exp_trig(input logic [7:0] d);
`ifdef UART_TRIG_CMD_FILTER_EN
        return d == 8'h44;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic hold(input logic level, input int n);
        rx_serial = level;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first, driven on falling clock edges.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, SYM);
        for (int i = 0; i < 8; i++) hold(b[i], SYM);
        hold(stop_bit, SYM);
    endtask

    task automatic expect_valid(input logic [7:0] b);
        exp_q.push_back('{is_valid: 1'b1, dat: b, trig: exp_trig(b)});
    endtask

    // Monitor: every strobe pops one expected event.
    always @(negedge clk) begin
        if (rx_valid && rx_frame_err) begin
            errors++;
            $display("FAIL strobe_overlap: rx_valid=1 rx_frame_err=1, expected never both");
        end
        if (trig && !rx_valid) begin
            errors++;
            $display("FAIL trig_alone: trig=1 rx_valid=%0b, expected trig only with rx_valid", rx_valid);
        end
        if (rx_valid || rx_frame_err) begin
            vectors++;
            if (rx_valid) last_valid_t = $time;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: valid=%0b ferr=%0b dat=0x%0h, expected no strobe",
                         rx_valid, rx_frame_err, rx_dat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rx_valid !== e.is_valid || rx_frame_err !== !e.is_valid ||
                    rx_dat !== e.dat || trig !== e.trig) begin
                    errors++;
                    $display("FAIL strobe: got valid=%0b ferr=%0b dat=0x%0h trig=%0b, expected valid=%0b ferr=%0b dat=0x%0h trig=%0b",
                             rx_valid, rx_frame_err, rx_dat, trig,
                             e.is_valid, !e.is_valid, e.dat, e.trig);
                end
            end
        end
    end

    initial begin
        time t_fall;
        int  lat;
        int  waited;

        // Reset with the line low; synchroniser must still come out idle.
        repeat (5) @(negedge clk);
        rx_serial = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check("rst_rx_dat",   32'(rx_dat), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr",     32'(rx_frame_err), 32'h0);
        check("rst_trig",     32'(trig), 32'h0);
        check("rst_busy",     32'(rx_busy), 32'h0);
        hold(1'b1, 4);

        expect_valid(8'hA5);
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 8);

        // Back-to-back frames, no idle between stop and next start.
        expect_valid(8'h44);
        expect_valid(8'h45);
        send_frame(8'h44, 1'b1);
        send_frame(8'h45, 1'b1);
        hold(1'b1, 8);

        // Glitch shorter than half a bit.
        hold(1'b0, 4);
        check("glitch_busy_high", 32'(rx_busy), 32'h1);
        rx_serial = 1'b1;
        waited = 0;
        while (rx_busy && waited < int'(SYM / 2 + 3)) begin
            @(negedge clk);
            waited++;
        end
        check("glitch_busy_drop", 32'(rx_busy), 32'h0);
        hold(1'b1, 8);

        // Framing error then a held-low break; rx_dat keeps 0x45.
        exp_q.push_back('{is_valid: 1'b0, dat: 8'h45, trig: 1'b0});
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 20);
        expect_valid(8'h44);
        send_frame(8'h44, 1'b1);
        hold(1'b1, 8);

        // Falling edge to rx_valid latency.
        expect_valid(8'h5A);
        t_fall = $time;
        send_frame(8'h5A, 1'b1);
        lat = int'((last_valid_t - t_fall) / 10);
        check("latency_in_window", 32'(lat >= 154 && lat <= 156), 32'h1);
        hold(1'b1, 8);

        // Reset during data bit 4 abandons the frame.
        hold(1'b0, SYM);
        hold(1'b1, SYM);
        hold(1'b0, SYM);
        hold(1'b1, SYM);
        hold(1'b0, SYM);
        hold(1'b1, SYM / 2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx_serial = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        hold(1'b1, 10);
        check("midrst_rx_dat", 32'(rx_dat), 32'h0);
        expect_valid(8'h01);
        send_frame(8'h01, 1'b1);
        hold(1'b1, 20);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_trig_rx.md
Name: uart_trig_rx

Overview:
- Serial receive front end for the phase-capture dump path.
- Deserialises 8N1 UART bytes from the host and presents each byte with a one-cycle valid strobe.
- Derives a one-cycle trig pulse that drives the capture block's fpga_rx trigger input.
- Bit timing uses the same sym_cnt convention as the existing transmitter (clk_freq / sym_rate).

Parameters:
- sym_cnt, 40000, clocks per bit (48 MHz / 1200 baud).
- SCW, $clog2(sym_cnt), width of the bit-rate counter.
- TRIG_BYTE, 8'h44 ('D'), command byte that fires trig when the CMD_FILTER_EN feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets).
- rx_serial  in  1  asynchronous UART line; idles high.
- rx_dat  out  8  last good received byte.
- rx_valid  out  1  one-cycle strobe; rx_dat is new.
- rx_frame_err  out  1  one-cycle strobe; stop bit was read as 0.
- trig  out  1  one-cycle capture trigger.
- rx_busy  out  1  high while a frame is in progress, i.e. any state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - Both synchroniser flops go to 1.
  - rx_dat = 0; rx_valid, rx_frame_err, trig and rx_busy = 0.
  - Rate counter and bit index clear.
  - Reset mid-frame abandons the frame; no strobe is emitted.
- Synchroniser: 2 flops on rx_serial. All logic below uses the output of the second flop (rxs).
- State IDLE:
  - rxs=0 loads the rate counter with 0 and moves to START.
- State START:
  - Counts to sym_cnt/2 - 1 (integer division), then samples rxs.
  - rxs=1 is a glitch or false start: return to IDLE with no strobe.
  - rxs=0: clear the counter and the bit index, then go to DATA.
- State DATA:
  - Each time the counter reaches sym_cnt-1, sample rxs into the shift register LSB-first, clear the counter and increment the bit index.
  - After the 8th bit, go to STOP.
- State STOP:
  - At count sym_cnt-1, sample rxs.
  - rxs=1: load rx_dat from the shift register, pulse rx_valid for exactly 1 cycle on the next clock, go to IDLE.
  - rxs=0: pulse rx_frame_err for 1 cycle, leave rx_dat unchanged, go to BREAK.
- State BREAK:
  - Wait for rxs=1, then go to IDLE.
  - A held-low line therefore produces exactly one rx_frame_err and no further frames.
- Latency: rx_valid asserts 2 + sym_cnt/2 + 9*sym_cnt + 1 clocks, ±1, after the falling edge on rx_serial.
- Timing rules:
  - rx_valid and rx_frame_err never assert in the same cycle.
  - Back-to-back frames with zero idle time are accepted. The falling edge is detected in IDLE on the first cycle after STOP.
- trig:
  - A one-cycle pulse coincident with rx_valid when the byte is accepted (see Optional Feature).
  - Never asserts with rx_frame_err.
- Counter width:
  - The counter is SCW bits and compares against sym_cnt-1 explicitly.
  - It never wraps during a frame.
  - sym_cnt must be >= 4.

Optional Feature:
- Macro: UART_TRIG_CMD_FILTER_EN.
- Defined: trig fires only when the received byte equals TRIG_BYTE. Other valid bytes produce rx_valid without trig.
- Undefined: every valid byte fires trig (any keypress arms a dump). TRIG_BYTE is unused.

Test Plan:
- Bench parameters: sym_cnt=16, SCW=4.
- Reset: hold rst=0 for 5 cycles with rx_serial=0, release with the line high.
  - Required: all outputs 0, rx_busy=0.
  - Then send byte 8'hA5: rx_valid for 1 cycle, rx_dat=8'hA5, rx_frame_err=0.
- Filter: with the macro defined, send 8'h44 then 8'h45 back-to-back with no idle.
  - Required: two rx_valid strobes, rx_dat=8'h44 then 8'h45, and trig only with the first.
  - Rebuild without the macro: trig fires with both.
- Glitch: drive rx_serial low for 4 clocks, then high.
  - Required: returns to IDLE, rx_busy drops within sym_cnt/2+3 cycles, no strobes.
- Framing error: send 8'h3C with the stop bit forced to 0, then hold the line low for 40 cycles, then send 8'h44.
  - Required: exactly one rx_frame_err and no rx_valid for the bad frame, with rx_dat holding its prior value.
  - Required: a clean rx_valid with rx_dat=8'h44 after the line returns high.
- Reset mid-frame: assert rst=0 during data bit 4 of a frame, release, then send 8'h01.
  - Required: no strobe for the aborted frame, then rx_dat=8'h01 with rx_valid.
- Latency: measure from the rx_serial falling edge to rx_valid.
  - Required: 2 + 8 + 144 + 1 = 155 clocks, ±1.
